// File: rtl/dpram_port_arb_if.sv
// dpram_port_arb_if
//   Bundles the EMIF command port, the local req/gnt port, the RAM port and
//   the error flags of dpram_port_arb.
//   slave  : arbiter side (drives ram_*, read returns, loc_gnt, flags)
//   master : environment side (drives commands, local requests, ram_rdata)
interface dpram_port_arb_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              emif_wen;
    logic              emif_ren;
    logic [23:0]       emif_addr;
    logic [DATA_W-1:0] emif_wdata;
    logic [DATA_W-1:0] emif_rdata;
    logic              emif_rvalid;

    logic              loc_req;
    logic              loc_we;
    logic [ADDR_W-1:0] loc_addr;
    logic [DATA_W-1:0] loc_wdata;
    logic              loc_gnt;
    logic [DATA_W-1:0] loc_rdata;
    logic              loc_rvalid;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              emif_ovf;
    logic              cmd_err;
    logic              err_clr;

    modport slave (
        input  emif_wen, emif_ren, emif_addr, emif_wdata,
        output emif_rdata, emif_rvalid,
        input  loc_req, loc_we, loc_addr, loc_wdata,
        output loc_gnt, loc_rdata, loc_rvalid,
        output ram_we, ram_re, ram_addr, ram_wdata,
        input  ram_rdata,
        output emif_ovf, cmd_err,
        input  err_clr
    );

    modport master (
        output emif_wen, emif_ren, emif_addr, emif_wdata,
        input  emif_rdata, emif_rvalid,
        output loc_req, loc_we, loc_addr, loc_wdata,
        input  loc_gnt, loc_rdata, loc_rvalid,
        input  ram_we, ram_re, ram_addr, ram_wdata,
        output ram_rdata,
        input  emif_ovf, cmd_err,
        output err_clr
    );
endinterface

// File: rtl/dpram_port_arb.sv
// dpram_port_arb
//   Shares the single read/write port of the dual-port RAM between the EMIF
//   front end (unthrottled command pulses, buffered in a FIFO, priority) and
//   local logic (req/gnt handshake, protected by a starvation guard).
//   Read data is routed back to whichever requester issued the read.
// Ports
//   clk_100m : system clock
//   rst      : asynchronous active-high reset
//   bus      : dpram_port_arb_if.slave (EMIF, local, RAM and error signals)
module dpram_port_arb #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk_100m,
    input  logic                  rst,
    dpram_port_arb_if.slave       bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t              fifo_mem [FIFO_DEPTH];
    cmd_t              push_cmd;
    cmd_t              head;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              empty, full, push, push_ok, pop;
    logic              gnt, force_loc, cmd_both, ovf_set;
    logic [WW-1:0]     wait_cnt;
    logic              ram_tag;                 // owner of the op now on ram_*: 1 = local
    logic [RD_LAT:1]   vld_pipe, tag_pipe;

    // Simultaneous wen/ren collapses to a write; the read is dropped.
    assign push     = bus.emif_wen | bus.emif_ren;
    assign cmd_both = bus.emif_wen & bus.emif_ren;
    assign push_cmd = {bus.emif_wen, bus.emif_addr[ADDR_W-1:0], bus.emif_wdata};

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign head     = fifo_mem[rd_ptr];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push & (~full | pop);
    assign ovf_set  = push & full & ~pop;

    assign force_loc = bus.loc_req && (wait_cnt >= WW'(MAX_WAIT));

    always_comb begin
        gnt = 1'b0;
        pop = 1'b0;
        if (force_loc)       gnt = 1'b1;
        else if (!empty)     pop = 1'b1;
        else if (bus.loc_req) gnt = 1'b1;
    end

    assign bus.loc_gnt = gnt;

    // FIFO storage carries no reset; occupancy is defined by count alone.
    always_ff @(posedge clk_100m) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_cmd;
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst)                      wait_cnt <= '0;
        else if (!bus.loc_req || gnt) wait_cnt <= '0;
        else if (wait_cnt < WW'(MAX_WAIT)) wait_cnt <= wait_cnt + WW'(1);
    end

    // Arbitration result lands on the RAM port one edge later; address and
    // write data hold their last value when idle.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            bus.ram_we    <= 1'b0;
            bus.ram_re    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            ram_tag       <= 1'b0;
        end else begin
            bus.ram_we <= 1'b0;
            bus.ram_re <= 1'b0;
            if (gnt) begin
                bus.ram_we    <= bus.loc_we;
                bus.ram_re    <= ~bus.loc_we;
                bus.ram_addr  <= bus.loc_addr;
                bus.ram_wdata <= bus.loc_wdata;
                ram_tag       <= 1'b1;
            end else if (pop) begin
                bus.ram_we    <= head.we;
                bus.ram_re    <= ~head.we;
                bus.ram_addr  <= head.addr;
                bus.ram_wdata <= head.wdata;
                ram_tag       <= 1'b0;
            end
        end
    end

    // Owner tag travels with each read; stage RD_LAT lines up with ram_rdata.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            vld_pipe        <= '0;
            tag_pipe        <= '0;
            bus.emif_rvalid <= 1'b0;
            bus.loc_rvalid  <= 1'b0;
            bus.emif_rdata  <= '0;
            bus.loc_rdata   <= '0;
        end else begin
            vld_pipe[1] <= bus.ram_re;
            tag_pipe[1] <= ram_tag;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
            bus.emif_rvalid <= vld_pipe[RD_LAT] & ~tag_pipe[RD_LAT];
            bus.loc_rvalid  <= vld_pipe[RD_LAT] &  tag_pipe[RD_LAT];
            if (vld_pipe[RD_LAT] && !tag_pipe[RD_LAT]) bus.emif_rdata <= bus.ram_rdata;
            if (vld_pipe[RD_LAT] &&  tag_pipe[RD_LAT]) bus.loc_rdata  <= bus.ram_rdata;
        end
    end

    // Sticky flags; a set condition beats err_clr in the same cycle.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            bus.cmd_err  <= 1'b0;
            bus.emif_ovf <= 1'b0;
        end else begin
            if (cmd_both)         bus.cmd_err <= 1'b1;
            else if (bus.err_clr) bus.cmd_err <= 1'b0;
            if (ovf_set)          bus.emif_ovf <= 1'b1;
            else if (bus.err_clr) bus.emif_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dpram_port_arb.sv
module tb_dpram_port_arb;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dpram_port_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    dpram_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4),
                     .RD_LAT(2), .MAX_WAIT(8)) dut (
        .clk_100m (clk),
        .rst      (rst),
        .bus      (bus)
    );

    // RAM model with two-cycle read latency; 16'hDEAD outside the valid slot
    logic [DATA_W-1:0] mem [4096];
    logic              rp1_v = 1'b0, rp2_v = 1'b0;
    logic [ADDR_W-1:0] rp1_a = '0, rp2_a = '0;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        rp1_v <= bus.ram_re;
        rp1_a <= bus.ram_addr;
        rp2_v <= rp1_v;
        rp2_a <= rp1_a;
    end
    assign bus.ram_rdata = rp2_v ? mem[rp2_a] : 16'hDEAD;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { bit we; int addr; int wdata; int cy; } ram_exp_t;
    typedef struct { int data; int cy; } rd_exp_t;
    ram_exp_t exp_ram[$];
    rd_exp_t  exp_emif[$];
    rd_exp_t  exp_loc[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_ram(bit we, int addr, int wdata, int cy);
        ram_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.cy = cy;
        exp_ram.push_back(e);
    endtask

    task automatic push_rd(bit loc, int data, int cy);
        rd_exp_t e;
        e.data = data; e.cy = cy;
        if (loc) exp_loc.push_back(e);
        else     exp_emif.push_back(e);
    endtask

    // Monitor: every RAM op and rvalid pulse is matched against the queues
    initial begin
        ram_exp_t er;
        rd_exp_t  ed;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.ram_we || bus.ram_re) begin
                    if (exp_ram.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL ram_unexpected: we=%0b re=%0b addr=%0h, none expected (cycle %0d)",
                                 bus.ram_we, bus.ram_re, bus.ram_addr, cyc);
                    end else begin
                        er = exp_ram.pop_front();
                        chk("ram_we", 32'(bus.ram_we), 32'(er.we));
                        chk("ram_re", 32'(bus.ram_re), 32'(!er.we));
                        chk("ram_addr", 32'(bus.ram_addr), er.addr);
                        if (er.we) chk("ram_wdata", 32'(bus.ram_wdata), er.wdata);
                        chk("ram_cycle", cyc, er.cy);
                    end
                end
                if (bus.emif_rvalid) begin
                    if (exp_emif.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL emif_rvalid_unexpected: data=%0h, none expected (cycle %0d)",
                                 bus.emif_rdata, cyc);
                    end else begin
                        ed = exp_emif.pop_front();
                        chk("emif_rdata", 32'(bus.emif_rdata), ed.data);
                        chk("emif_rvalid_cycle", cyc, ed.cy);
                    end
                end
                if (bus.loc_rvalid) begin
                    if (exp_loc.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL loc_rvalid_unexpected: data=%0h, none expected (cycle %0d)",
                                 bus.loc_rdata, cyc);
                    end else begin
                        ed = exp_loc.pop_front();
                        chk("loc_rdata", 32'(bus.loc_rdata), ed.data);
                        chk("loc_rvalid_cycle", cyc, ed.cy);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit wen, bit ren, logic [23:0] ea, logic [15:0] ed,
                         bit lreq, bit lwe, logic [11:0] la, logic [15:0] ld);
        bus.emif_wen   = wen;
        bus.emif_ren   = ren;
        bus.emif_addr  = ea;
        bus.emif_wdata = ed;
        bus.loc_req    = lreq;
        bus.loc_we     = lwe;
        bus.loc_addr   = la;
        bus.loc_wdata  = ld;
    endtask

    task automatic idle();
        drive(0, 0, 24'h0, 16'h0, 0, 0, 12'h0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, s, g, gcyc;
        bit got, lreq;

        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h010] = 16'h1234;
        mem[12'h020] = 16'h5A5A;
        mem[12'h030] = 16'h1111;
        mem[12'h040] = 16'h2222;
        mem[12'h050] = 16'h3333;

        bus.err_clr = 1'b0;
        idle();
        rst = 1'b1;
        repeat (3) tick();

        // reset state
        chk("rst_ram_we",      32'(bus.ram_we), 0);
        chk("rst_ram_re",      32'(bus.ram_re), 0);
        chk("rst_ram_addr",    32'(bus.ram_addr), 0);
        chk("rst_ram_wdata",   32'(bus.ram_wdata), 0);
        chk("rst_emif_rvalid", 32'(bus.emif_rvalid), 0);
        chk("rst_loc_rvalid",  32'(bus.loc_rvalid), 0);
        chk("rst_emif_ovf",    32'(bus.emif_ovf), 0);
        chk("rst_cmd_err",     32'(bus.cmd_err), 0);
        rst = 1'b0;
        repeat (2) tick();

        // single EMIF write: RAM write two cycles after the pulse
        c = cyc;
        drive(1, 0, 24'h000123, 16'hA5A5, 0, 0, 12'h0, 16'h0);
        push_ram(1, 'h123, 'hA5A5, c + 2);
        tick(); idle();
        repeat (4) tick();

        // single EMIF read of 0x010
        c = cyc;
        drive(0, 1, 24'h000010, 16'h0, 0, 0, 12'h0, 16'h0);
        push_ram(0, 'h010, 0, c + 2);
        push_rd(0, 'h1234, c + 5);
        tick(); idle();
        repeat (8) tick();

        // starvation guard: local read forced through at wait_cnt = 8
        s = cyc; got = 0; gcyc = -1;
        for (int k = 0; k < 8; k++) push_ram(1, 'h100 + k, 'h1000 + k, s + k + 2);
        push_ram(0, 'h020, 0, s + 10);
        for (int k = 8; k < 10; k++) push_ram(1, 'h100 + k, 'h1000 + k, s + k + 3);
        push_rd(1, 'h5A5A, s + 13);
        for (int i = 0; i < 10; i++) begin
            lreq = (i >= 1) && !got;
            drive(1, 0, 24'(24'h000100 + i), 16'(16'h1000 + i), lreq, 0, 12'h020, 16'h0);
            #1;
            if (bus.loc_gnt && lreq) begin got = 1; gcyc = cyc; end
            tick();
        end
        idle();
        chk("loc_gnt_forced_cycle", gcyc - s, 9);
        repeat (10) tick();
        chk("no_ovf_under_load", 32'(bus.emif_ovf), 0);

        // sustained EMIF stream with repeated forced local writes -> one drop
        s = cyc; g = 0;
        for (int grp = 0; grp < 4; grp++) begin
            for (int j = 0; j < 8; j++)
                push_ram(1, 'h300 + 8*grp + j, 'h3000 + 8*grp + j, s + 8*grp + j + grp + 2);
            push_ram(1, 'h200 + grp, 'hC000 + grp, s + 9*grp + 10);
        end
        for (int k = 32; k < 36; k++) push_ram(1, 'h300 + k, 'h3000 + k, s + k + 6);
        for (int t = 0; t <= 40; t++) begin
            if (t == 36) chk("ovf_before_drop", 32'(bus.emif_ovf), 0);
            if (t == 37) chk("ovf_after_drop", 32'(bus.emif_ovf), 1);
            lreq = (t >= 1) && (g < 4);
            drive(t <= 36, 0, 24'(24'hAB0300 + t), 16'(16'h3000 + t),
                  lreq, 1, 12'(12'h200 + g), 16'(16'hC000 + g));
            #1;
            if (bus.loc_gnt && lreq) g++;
            tick();
        end
        idle();
        repeat (5) tick();
        chk("loc_grants_in_stream", g, 4);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("ovf_cleared", 32'(bus.emif_ovf), 0);
        repeat (2) tick();

        // interleaved EMIF / local / EMIF reads, back to back
        c = cyc;
        push_ram(0, 'h030, 0, c + 2);
        push_ram(0, 'h040, 0, c + 3);
        push_ram(0, 'h050, 0, c + 4);
        push_rd(0, 'h1111, c + 5);
        push_rd(1, 'h2222, c + 6);
        push_rd(0, 'h3333, c + 7);
        drive(0, 1, 24'h000030, 16'h0, 0, 0, 12'h0, 16'h0);
        tick();
        drive(0, 0, 24'h0, 16'h0, 1, 0, 12'h040, 16'h0);
        #1; chk("loc_gnt_wait_fifo", 32'(bus.loc_gnt), 0);
        tick();
        drive(0, 1, 24'h000050, 16'h0, 1, 0, 12'h040, 16'h0);
        #1; chk("loc_gnt_fifo_empty", 32'(bus.loc_gnt), 1);
        tick(); idle();
        repeat (8) tick();

        // reset with two reads in flight
        c = cyc;
        push_ram(0, 'h030, 0, c + 2);
        drive(0, 1, 24'h000030, 16'h0, 0, 0, 12'h0, 16'h0);
        tick();
        drive(0, 1, 24'h000050, 16'h0, 0, 0, 12'h0, 16'h0);
        tick(); idle();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_ram_re",      32'(bus.ram_re), 0);
        chk("midrst_ram_addr",    32'(bus.ram_addr), 0);
        chk("midrst_emif_rvalid", 32'(bus.emif_rvalid), 0);
        chk("midrst_loc_rvalid",  32'(bus.loc_rvalid), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (8) tick();
        c = cyc;
        drive(1, 0, 24'h000777, 16'hBEEF, 0, 0, 12'h0, 16'h0);
        push_ram(1, 'h777, 'hBEEF, c + 2);
        tick(); idle();
        repeat (4) tick();

        // wen+ren collision: write kept, cmd_err set, set beats clear
        c = cyc;
        drive(1, 1, 24'h000060, 16'h6666, 0, 0, 12'h0, 16'h0);
        push_ram(1, 'h060, 'h6666, c + 2);
        tick();
        chk("cmd_err_set", 32'(bus.cmd_err), 1);
        drive(1, 1, 24'h000061, 16'h6161, 0, 0, 12'h0, 16'h0);
        bus.err_clr = 1'b1;
        push_ram(1, 'h061, 'h6161, c + 3);
        tick();
        bus.err_clr = 1'b0;
        idle();
        chk("cmd_err_set_wins", 32'(bus.cmd_err), 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("cmd_err_cleared", 32'(bus.cmd_err), 0);
        repeat (4) tick();

        // everything expected must have been seen
        for (int i = 0; i < 50; i++) begin
            if (exp_ram.size() == 0 && exp_emif.size() == 0 && exp_loc.size() == 0) break;
            tick();
        end
        chk("scoreboard_drained", exp_ram.size() + exp_emif.size() + exp_loc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
